perf_display_ctrl: RTL and testbench

- Parametrised successor to the fixed six-digit hex performance readout: periodically snapshots a VALUE_W-bit metric and produces NUM_DIGITS 4-bit digit codes for external seg7 decoders.
- Adds a decimal mode using a sequential double-dabble conversion, a hold/freeze input, leading-zero blanking, overflow flagging and an update strobe.
- Sits between a solver's performance output and the HEX display instances in the board top level.

---
 rtl/perf_display_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_perf_display_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_display_ctrl.sv
// perf_display_ctrl: takes periodic snapshots of a performance metric and
// turns each one into NUM_DIGITS 4-bit digit codes for external seg7 decoders.
// Hex mode passes the nibbles through. Decimal mode runs a sequential
// double-dabble conversion, one input bit per cycle.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low (0 = reset)
//   value        metric to display, sampled only at a snapshot
//   mode_dec     1 = decimal, 0 = hex, sampled at a snapshot
//   hold         1 = ignore refresh ticks, so the display stays frozen
//   blank_lz     1 = blank leading zero digits
//   digits       packed digit codes, digit i at [4i+3:4i], digit 0 = LSD
//   digit_blank  1 = digit i should be dark
//   overflow     value did not fit in NUM_DIGITS digits at the last commit
//   busy         decimal conversion in progress
//   update       one-cycle pulse on every digits commit
module perf_display_ctrl #(
    parameter int unsigned VALUE_W      = 32,
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned REFRESH_LOG2 = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    mode_dec,
    input  logic                    hold,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS*4-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    overflow,
    output logic                    busy,
    output logic                    update
);

    localparam int unsigned DIG_W = NUM_DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [REFRESH_LOG2-1:0] tick_cnt_q;
    logic                    tick_c;

    logic [VALUE_W-1:0] snap_q, snap_d;
    logic               mode_q, mode_d;
    logic [DIG_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;

    logic [DIG_W-1:0]      digits_q, digits_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic                  update_q, update_d;

    logic [DIG_W-1:0] bcd_adj;
    logic [DIG_W-1:0] hex_digits;
    logic             hex_ovf;
    logic             lz_run;

    assign digits      = digits_q;
    assign digit_blank = blank_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;
    assign update      = update_q;

    // Free-running refresh counter; a tick fires whenever it reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + REFRESH_LOG2'(1);
        end
    end

    assign tick_c = (tick_cnt_q == '0);

    // Hex view of the snapshot: truncate to the display width, or zero-extend
    if (VALUE_W > DIG_W) begin : g_hex_wide
        assign hex_digits = snap_q[DIG_W-1:0];
        assign hex_ovf    = |snap_q[VALUE_W-1:DIG_W];
    end else begin : g_hex_narrow
        assign hex_digits = DIG_W'(snap_q);
        assign hex_ovf    = 1'b0;
    end

    // Double-dabble correction: add 3 to every BCD nibble of 5 or more before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Ticks that arrive outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tick_c && !hold) begin
                    state_d = mode_dec ? S_SHIFT : S_COMMIT;
                end
            end
            S_SHIFT: begin
                if (bitcnt_q == CNT_W'(1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Snapshot and conversion datapath
    always_comb begin
        snap_d   = snap_q;
        mode_d   = mode_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            S_IDLE: begin
                if (tick_c && !hold) begin
                    snap_d   = value;
                    mode_d   = mode_dec;
                    bcd_d    = '0;
                    ovf_d    = 1'b0;
                    bitcnt_d = CNT_W'(VALUE_W);
                end
            end
            S_SHIFT: begin
                // Shift {bcd, snap} left by one. A 1 leaving the BCD MSB means value >= 10^NUM_DIGITS.
                {bcd_d, snap_d} = {bcd_adj[DIG_W-2:0], snap_q, 1'b0};
                ovf_d           = ovf_q | bcd_adj[DIG_W-1];
                bitcnt_d        = bitcnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Output next values; the result is committed only in COMMIT
    always_comb begin
        digits_d   = digits_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;
        update_d   = 1'b0;
        busy_d     = (state_d == S_SHIFT);
        lz_run     = 1'b0;
        if (state_q == S_COMMIT) begin
            update_d = 1'b1;
            if (mode_q) begin
                digits_d   = bcd_q;
                overflow_d = ovf_q;
            end else begin
                digits_d   = hex_digits;
                overflow_d = hex_ovf;
            end
            // Blank from the top digit down until the first nonzero digit. Digit 0 always stays lit.
            blank_d = '0;
            lz_run  = blank_lz && !overflow_d;
            for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
                lz_run     = lz_run && (digits_d[4*i +: 4] == 4'h0);
                blank_d[i] = lz_run;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q     <= '0;
            mode_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            bitcnt_q   <= '0;
            digits_q   <= {NUM_DIGITS{4'hF}};
            blank_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            update_q   <= 1'b0;
        end else begin
            snap_q     <= snap_d;
            mode_q     <= mode_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            bitcnt_q   <= bitcnt_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            update_q   <= update_d;
        end
    end

endmodule

// File: tb/tb_perf_display_ctrl.sv
// Bench for perf_display_ctrl. Three instances (6, 4 and 3 digits) share the
// same stimulus. Commits from the 6-digit instance are checked against a
// scoreboard of expected results.
module tb_perf_display_ctrl;

    localparam int unsigned W = 16;
    localparam int unsigned R = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] value;
    logic         mode_dec, hold, blank_lz;

    logic [23:0] d6;  logic [5:0] b6;  logic o6, busy6, u6;
    logic [15:0] d4;  logic [3:0] b4;  logic o4, busy4, u4;
    logic [11:0] d3;  logic [2:0] b3;  logic o3, busy3, u3;

    perf_display_ctrl #(.VALUE_W(W), .NUM_DIGITS(6), .REFRESH_LOG2(R)) dut6 (
        .clk(clk), .rst(rst), .value(value), .mode_dec(mode_dec), .hold(hold),
        .blank_lz(blank_lz), .digits(d6), .digit_blank(b6), .overflow(o6),
        .busy(busy6), .update(u6));

    perf_display_ctrl #(.VALUE_W(W), .NUM_DIGITS(4), .REFRESH_LOG2(R)) dut4 (
        .clk(clk), .rst(rst), .value(value), .mode_dec(mode_dec), .hold(hold),
        .blank_lz(blank_lz), .digits(d4), .digit_blank(b4), .overflow(o4),
        .busy(busy4), .update(u4));

    perf_display_ctrl #(.VALUE_W(W), .NUM_DIGITS(3), .REFRESH_LOG2(R)) dut3 (
        .clk(clk), .rst(rst), .value(value), .mode_dec(mode_dec), .hold(hold),
        .blank_lz(blank_lz), .digits(d3), .digit_blank(b3), .overflow(o3),
        .busy(busy3), .update(u3));

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] dig;
        logic [5:0]  blk;
        logic        ovf;
        int          edge_at;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_n      = 0;
    logic seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic push_exp(input logic [23:0] dig, input logic [5:0] blk,
                            input logic ovf, input int edge_at);
        exp_t e;
        e.dig = dig; e.blk = blk; e.ovf = ovf; e.edge_at = edge_at;
        sb.push_back(e);
    endtask

    // Wait for the next update pulse (bounded) and compare it to the oldest expectation
    task automatic wait_commit(input string tag);
        exp_t e;
        logic got;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            step();
            if (u6 === 1'b1) got = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, "_update_seen"}, 64'(got), 64'(1));
        if (got) begin
            chk({tag, "_edge"},   64'(edge_n), 64'(e.edge_at));
            chk({tag, "_digits"}, 64'(d6),     64'(e.dig));
            chk({tag, "_blank"},  64'(b6),     64'(e.blk));
            chk({tag, "_ovf"},    64'(o6),     64'(e.ovf));
        end
    endtask

    initial begin
        rst      = 1'b0;
        value    = 16'hBEEF;
        mode_dec = 1'b0;
        hold     = 1'b0;
        blank_lz = 1'b0;
        seen     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", 64'(d6),    64'h00FF_FFFF);
        chk("rst_blank",  64'(b6),    64'(0));
        chk("rst_ovf",    64'(o6),    64'(0));
        chk("rst_busy",   64'(busy6), 64'(0));
        chk("rst_update", 64'(u6),    64'(0));

        // Hex 0xBEEF: tick on edge 1, commit visible after edge 2
        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
        push_exp(24'h00BEEF, 6'b000000, 1'b0, 2);
        step();
        chk("hex_pre_digits", 64'(d6), 64'h00FF_FFFF);
        chk("hex_pre_update", 64'(u6), 64'(0));
        wait_commit("hex_beef");
        chk("hex4_digits", 64'(d4), 64'hBEEF);
        chk("hex4_ovf",    64'(o4), 64'(0));
        chk("hex3_digits", 64'(d3), 64'hEEF);
        chk("hex3_ovf",    64'(o3), 64'(1));
        step();
        chk("hex_update_once", 64'(u6), 64'(0));

        // Decimal 12345 with leading-zero blanking: tick on edge 33, commit after edge 50
        mode_dec = 1'b1;
        value    = 16'd12345;
        blank_lz = 1'b1;
        push_exp(24'h012345, 6'b100000, 1'b0, 50);
        run_to(40);
        chk("dec_busy_mid",     64'(busy6), 64'(1));
        chk("dec_digits_stale", 64'(d6),    64'h00BEEF);
        wait_commit("dec_12345");
        chk("dec_busy_done", 64'(busy6), 64'(0));
        chk("dec4_digits",   64'(d4),    64'h2345);
        chk("dec4_ovf",      64'(o4),    64'(1));
        chk("dec4_blank",    64'(b4),    64'(0));
        chk("dec3_digits",   64'(d3),    64'h345);
        chk("dec3_ovf",      64'(o3),    64'(1));

        // Decimal zero: everything blanked except digit 0
        value = 16'd0;
        push_exp(24'h000000, 6'b111110, 1'b0, 82);
        wait_commit("dec_zero");
        chk("zero4_blank", 64'(b4), 64'b1110);
        chk("zero3_blank", 64'(b3), 64'b110);

        // Hex 0x1234 with blanking; the 3-digit instance overflows
        mode_dec = 1'b0;
        value    = 16'h1234;
        push_exp(24'h001234, 6'b110000, 1'b0, 98);
        wait_commit("hex_1234");
        chk("hex1234_3_digits", 64'(d3), 64'h234);
        chk("hex1234_3_ovf",    64'(o3), 64'(1));
        chk("hex1234_3_blank",  64'(b3), 64'(0));
        chk("hex1234_4_digits", 64'(d4), 64'h1234);
        chk("hex1234_4_blank",  64'(b4), 64'(0));

        // Hold raised mid-conversion of 999: the in-flight result still commits
        mode_dec = 1'b1;
        value    = 16'd999;
        blank_lz = 1'b0;
        push_exp(24'h000999, 6'b000000, 1'b0, 146);
        run_to(135);
        hold = 1'b1;
        wait_commit("hold_inflight");
        value = 16'd42;
        while (edge_n < 250) begin
            step();
            if (u6 !== 1'b0) seen = 1'b1;
        end
        chk("hold_no_update", 64'(seen), 64'(0));
        chk("hold_digits",    64'(d6),   64'h000999);
        hold = 1'b0;
        push_exp(24'h000042, 6'b000000, 1'b0, 274);
        wait_commit("hold_release");

        // Asynchronous reset five cycles into a conversion
        value = 16'd4321;
        run_to(294);
        chk("arst_busy_before", 64'(busy6), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_digits", 64'(d6),    64'h00FF_FFFF);
        chk("arst_ovf",    64'(o6),    64'(0));
        chk("arst_busy",   64'(busy6), 64'(0));
        chk("arst_update", 64'(u6),    64'(0));
        chk("arst_blank",  64'(b6),    64'(0));
        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
        push_exp(24'h004321, 6'b000000, 1'b0, 18);
        wait_commit("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
